// File: rtl/keypad_scanner_4x4_if.sv
// Keypad scanner bus: matrix pins on one side, accepted-key reporting on the other.
// master = scanner, slave = keypad/consumer side.
interface keypad_scanner_4x4_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_onehot;
    logic        key_valid;
    logic        key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_onehot,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_onehot,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner with frame-based debounce.
// Drives one column low per slot, classifies each 4-slot frame as
// NONE / SINGLE(idx) / MULTI and debounces press and release over
// DEBOUNCE_FRAMES frames. Optional auto-repeat: define KEYPAD_REPEAT_EN.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | no key accepted, outputs cleared
// PRESS_DEB | counting identical SINGLE frames for candidate
// HELD      | key accepted, key_onehot/key_held asserted
// REL_DEB   | counting non-matching frames before release
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 250
) (
    input  logic                        clk,
    input  logic                        rst_n,
    keypad_scanner_4x4_if.master        kp
);
    localparam int              SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_N     = 4'(DEBOUNCE_FRAMES);
    localparam logic [3:0]      DEB_M1    = 4'(DEBOUNCE_FRAMES - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRESS_DEB = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;
    localparam logic [1:0] REL_DEB   = 2'd3;

    logic [3:0]        row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        frm_cnt_q, frm_cnt_d;
    logic [3:0]        frm_idx_q, frm_idx_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic [15:0]       key_onehot_q, key_onehot_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int             REP_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    logic       sample;
    logic       frame_end;
    logic [3:0] row_act;
    logic [2:0] col_hits;
    logic [1:0] row_pos;
    logic [2:0] hit_sum;
    logic [1:0] tot_cnt;
    logic [3:0] tot_idx;
    logic       f_single;
    logic       f_match;

    // Synchronizer and column scan timing.
    always_comb begin
        row_s1_d = kp.row_in;
        row_s2_d = row_s1_q;
        sample   = (slot_q == SLOT_LAST);
        slot_d   = sample ? '0 : slot_q + 1'b1;
        col_d    = sample ? col_q + 2'd1 : col_q;
    end

    // Per-slot row classification accumulated into a frame result (0, 1, or 2 = multi).
    always_comb begin
        row_act  = ~row_s2_q;
        col_hits = 3'd0;
        row_pos  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            col_hits = col_hits + 3'(row_act[r]);
            if (row_act[r]) row_pos = 2'(r);
        end
        hit_sum   = ((col_q == 2'd0) ? 3'd0 : 3'(frm_cnt_q)) + col_hits;
        tot_cnt   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_idx   = (col_hits == 3'd1) ? {row_pos, col_q} : frm_idx_q;
        frm_cnt_d = sample ? tot_cnt : frm_cnt_q;
        frm_idx_d = sample ? tot_idx : frm_idx_q;
        frame_end = sample && (col_q == 2'd3);
        f_single  = (tot_cnt == 2'd1);
        f_match   = f_single && (tot_idx == cand_q);
    end

    // Debounce state machine, evaluated once per frame.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        rcnt_d       = rcnt_q;
        key_onehot_d = key_onehot_q;
        key_held_d   = key_held_q;
        key_valid_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d        = rep_q;
`endif
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (f_single) begin
                        cand_d = tot_idx;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d      = HELD;
                            cnt_d        = DEB_N;
                            key_onehot_d = 16'd1 << tot_idx;
                            key_held_d   = 1'b1;
                            key_valid_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d        = '0;
`endif
                        end else begin
                            state_d = PRESS_DEB;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (f_match) begin
                        if (cnt_q >= DEB_M1) begin
                            state_d      = HELD;
                            cnt_d        = DEB_N;
                            key_onehot_d = 16'd1 << cand_q;
                            key_held_d   = 1'b1;
                            key_valid_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d        = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (f_single) begin
                        cand_d = tot_idx;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                HELD: begin
                    if (f_match) begin
`ifdef KEYPAD_REPEAT_EN
                        if (rep_q == REP_LAST) begin
                            rep_d       = '0;
                            key_valid_d = 1'b1;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
`else
                        state_d = HELD;
`endif
                    end else if (DEBOUNCE_FRAMES == 1) begin
                        state_d      = IDLE;
                        rcnt_d       = DEB_N;
                        key_onehot_d = 16'd0;
                        key_held_d   = 1'b0;
                    end else begin
                        state_d = REL_DEB;
                        rcnt_d  = 4'd1;
                    end
                end
                default: begin
                    if (f_match) begin
                        state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
`endif
                    end else if (rcnt_q >= DEB_M1) begin
                        state_d      = IDLE;
                        rcnt_d       = DEB_N;
                        key_onehot_d = 16'd0;
                        key_held_d   = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    // All state registers; async reset restarts the scan at col 0, slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q     <= 4'hF;
            row_s2_q     <= 4'hF;
            slot_q       <= '0;
            col_q        <= 2'd0;
            frm_cnt_q    <= 2'd0;
            frm_idx_q    <= 4'd0;
            state_q      <= IDLE;
            cand_q       <= 4'd0;
            cnt_q        <= 4'd0;
            rcnt_q       <= 4'd0;
            key_onehot_q <= 16'd0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q        <= '0;
`endif
        end else begin
            row_s1_q     <= row_s1_d;
            row_s2_q     <= row_s2_d;
            slot_q       <= slot_d;
            col_q        <= col_d;
            frm_cnt_q    <= frm_cnt_d;
            frm_idx_q    <= frm_idx_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            key_onehot_q <= key_onehot_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q        <= rep_d;
`endif
        end
    end

    assign kp.col_out    = ~(4'b0001 << col_q);
    assign kp.key_onehot = key_onehot_q;
    assign kp.key_valid  = key_valid_q;
    assign kp.key_held   = key_held_q;
endmodule
